// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite to SRAM bridge: response codes and FSM state encodings.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_mem_bridge_if.sv
// AXI4-Lite slave channels plus the SRAM-side strobes of the bridge, bundled as one interface.
interface axi4_lite_mem_bridge_if #(
  parameter int AXI_ALEN = 32,
  parameter int DLEN     = 32,
  parameter int MEM_ALEN = 4
);
  localparam int SLEN = DLEN / 8;

  logic                axi_awvalid, axi_awready;
  logic [AXI_ALEN-1:0] axi_awaddr;
  logic                axi_wvalid, axi_wready;
  logic [DLEN-1:0]     axi_wdata;
  logic [SLEN-1:0]     axi_wstrb;
  logic                axi_bvalid, axi_bready;
  logic [1:0]          axi_bresp;
  logic                axi_arvalid, axi_arready;
  logic [AXI_ALEN-1:0] axi_araddr;
  logic                axi_rvalid, axi_rready;
  logic [DLEN-1:0]     axi_rdata;
  logic [1:0]          axi_rresp;
  logic                mem_wen;
  logic [MEM_ALEN-1:0] mem_waddr;
  logic [DLEN-1:0]     mem_wdata;
  logic [SLEN-1:0]     mem_wstrb;
  logic                mem_ren;
  logic [MEM_ALEN-1:0] mem_raddr;
  logic [DLEN-1:0]     mem_rdata;
  logic                mem_rvalid;

  // Bridge side: AXI slave, memory master.
  modport slave (
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
           axi_arvalid, axi_araddr, axi_rready, mem_rdata, mem_rvalid,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp,
           mem_wen, mem_waddr, mem_wdata, mem_wstrb, mem_ren, mem_raddr
  );

  // Environment side: AXI master and memory responder.
  modport master (
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
           axi_arvalid, axi_araddr, axi_rready, mem_rdata, mem_rvalid,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp,
           mem_wen, mem_waddr, mem_wdata, mem_wstrb, mem_ren, mem_raddr
  );

endinterface

// File: rtl/axi4_lite_mem_rd_ctrl.sv
// Read path of the bridge: AR decode, one-cycle mem_ren, variable-latency wait with timeout, R response.
module axi4_lite_mem_rd_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int                  AXI_ALEN   = 32,
  parameter int                  DLEN       = 32,
  parameter int                  SLEN       = DLEN / 8,
  parameter int                  MEM_ALEN   = 4,
  parameter logic [AXI_ALEN-1:0] BASE_ADDR  = 'h4000_0000,
  parameter int                  RD_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                arvalid,
  output logic                arready,
  input  logic [AXI_ALEN-1:0] araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DLEN-1:0]     rdata,
  output logic [1:0]          rresp,
  output logic                mem_ren,
  output logic [MEM_ALEN-1:0] mem_raddr,
  input  logic [DLEN-1:0]     mem_rdata,
  input  logic                mem_rvalid
);

  localparam int            ADDR_LSB = $clog2(SLEN);
  localparam int            HI       = ADDR_LSB + MEM_ALEN;
  localparam int            CW       = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(RD_TIMEOUT - 1);

  function automatic logic in_range(input logic [AXI_ALEN-1:0] a);
    return (a >> HI) == (BASE_ADDR >> HI);
  endfunction

  rd_state_e           state, state_nx;
  logic [CW-1:0]       cnt_q;
  logic [MEM_ALEN-1:0] raddr_q;
  logic                ren_q;
  logic [DLEN-1:0]     rdata_q;
  resp_t               rresp_q;
  logic                ar_hs, hit, timeout;

  assign hit     = in_range(araddr);
  assign ar_hs   = arvalid && (state == RD_IDLE);
  assign timeout = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RD_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    arready  = 1'b0;
    case (state)
      RD_IDLE: begin
        arready = 1'b1;
        if (arvalid) state_nx = hit ? RD_WAIT : RD_RESP;
      end
      RD_WAIT: if (mem_rvalid || timeout) state_nx = RD_RESP;
      RD_RESP: if (rready) state_nx = RD_IDLE;
      default: state_nx = RD_IDLE;
    endcase
  end

  // Data capture: memory data wins over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      ren_q <= ar_hs && hit;
      if (ar_hs) begin
        raddr_q <= araddr[ADDR_LSB +: MEM_ALEN];
        cnt_q   <= '0;
        if (!hit) begin
          rdata_q <= '0;
          rresp_q <= DECERR;
        end
      end else if (state == RD_WAIT) begin
        if (mem_rvalid) begin
          rdata_q <= mem_rdata;
          rresp_q <= OKAY;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            rdata_q <= '0;
            rresp_q <= SLVERR;
          end
        end
      end
    end
  end

  assign rvalid    = (state == RD_RESP);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign mem_ren   = ren_q;
  assign mem_raddr = raddr_q;

endmodule

// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave to SRAM bridge: write FSM with independent AW/W ordering here, read path in a sub-module.
module axi4_lite_mem_bridge
  import axi4_lite_pkg::*;
#(
  parameter int                  AXI_ALEN   = 32,
  parameter int                  DLEN       = 32,
  parameter int                  SLEN       = DLEN / 8,
  parameter int                  MEM_ALEN   = 4,
  parameter logic [AXI_ALEN-1:0] BASE_ADDR  = 'h4000_0000,
  parameter int                  RD_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  axi4_lite_mem_bridge_if.slave  bus
);

  localparam int ADDR_LSB = $clog2(SLEN);
  localparam int HI       = ADDR_LSB + MEM_ALEN;

  function automatic logic in_range(input logic [AXI_ALEN-1:0] a);
    return (a >> HI) == (BASE_ADDR >> HI);
  endfunction

  wr_state_e           state, state_nx;
  logic                awready, wready, go;
  logic                aw_hs, w_hs;
  logic [MEM_ALEN-1:0] waddr_q, waddr_nx;
  logic                hit_q, hit_nx;
  logic [DLEN-1:0]     wdata_q;
  logic [SLEN-1:0]     wstrb_q, wstrb_nx;
  logic                wen_q;
  resp_t               bresp_q;

  assign aw_hs    = bus.axi_awvalid && awready;
  assign w_hs     = bus.axi_wvalid && wready;
  assign waddr_nx = aw_hs ? bus.axi_awaddr[ADDR_LSB +: MEM_ALEN] : waddr_q;
  assign hit_nx   = aw_hs ? in_range(bus.axi_awaddr) : hit_q;
  assign wstrb_nx = w_hs ? bus.axi_wstrb : wstrb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= WR_IDLE;
    else       state <= state_nx;
  end

  // go marks the cycle in which the second of AW/W is accepted.
  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    go       = 1'b0;
    case (state)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (bus.axi_awvalid && bus.axi_wvalid) begin
          go       = 1'b1;
          state_nx = WR_RESP;
        end else if (bus.axi_awvalid) state_nx = WR_HAVE_AW;
        else if (bus.axi_wvalid)      state_nx = WR_HAVE_W;
      end
      WR_HAVE_AW: begin
        wready = 1'b1;
        if (bus.axi_wvalid) begin
          go       = 1'b1;
          state_nx = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        awready = 1'b1;
        if (bus.axi_awvalid) begin
          go       = 1'b1;
          state_nx = WR_RESP;
        end
      end
      WR_RESP: if (bus.axi_bready) state_nx = WR_IDLE;
      default: state_nx = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q <= '0;
      hit_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
      bresp_q <= OKAY;
    end else begin
      waddr_q <= waddr_nx;
      hit_q   <= hit_nx;
      wstrb_q <= wstrb_nx;
      if (w_hs) wdata_q <= bus.axi_wdata;
      wen_q <= go && hit_nx && (|wstrb_nx);
      if (go)                                         bresp_q <= hit_nx ? OKAY : DECERR;
      else if (state == WR_RESP && bus.axi_bready)    bresp_q <= OKAY;
    end
  end

  assign bus.axi_awready = awready;
  assign bus.axi_wready  = wready;
  assign bus.axi_bvalid  = (state == WR_RESP);
  assign bus.axi_bresp   = bresp_q;
  assign bus.mem_wen     = wen_q;
  assign bus.mem_waddr   = waddr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wstrb   = wstrb_q;

  axi4_lite_mem_rd_ctrl #(
    .AXI_ALEN  (AXI_ALEN),
    .DLEN      (DLEN),
    .SLEN      (SLEN),
    .MEM_ALEN  (MEM_ALEN),
    .BASE_ADDR (BASE_ADDR),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_rd (
    .clk       (clk),
    .rstn      (rstn),
    .arvalid   (bus.axi_arvalid),
    .arready   (bus.axi_arready),
    .araddr    (bus.axi_araddr),
    .rvalid    (bus.axi_rvalid),
    .rready    (bus.axi_rready),
    .rdata     (bus.axi_rdata),
    .rresp     (bus.axi_rresp),
    .mem_ren   (bus.mem_ren),
    .mem_raddr (bus.mem_raddr),
    .mem_rdata (bus.mem_rdata),
    .mem_rvalid(bus.mem_rvalid)
  );

endmodule
